fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with IF/ID pipeline register.
//
// The stage issues one instruction-memory request at a time and waits 1..N cycles for the
// response. It buffers a returned word while IF/ID is stalled, drains stale responses after
// a redirect, and honours the hazard unit's PC enable, IF/ID enable and IF/ID flush.
//
// Optional feature: define FETCH_PERF_EN to add the perf_fetched, perf_wait and perf_flush
// counters. They wrap modulo 2^32. When the macro is undefined these ports are absent.
//
// Parameters
//   RESET_PC    PC value loaded on reset
//   NOP_INSTR   instruction word placed in IF/ID for a bubble
//
// Ports
//   clk, rst_n                       single clock; synchronous active-low reset
//   pc_src                           00 PC+4, 01 branch_target, 10 jump_target, 11 reg_target
//   branch_target/jump_target/reg_target   redirect addresses
//   PC_write, IFID_write, IF_flush   hazard controls: PC enable, IF/ID enable, IF/ID flush
//   imem_req, imem_addr              instruction-memory request
//   imem_ack, imem_rdata             instruction-memory response (rdata valid with ack)
//   pc                               current fetch PC
//   IFID_instruction/pc_plus4/valid  registered IF/ID outputs
//   fetch_busy                       waiting on memory, or holding a buffered word
//   perf_fetched/perf_wait/perf_flush  deliveries, cycles waiting on ack, flush cycles
//                                    (FETCH_PERF_EN only)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] reg_target,
  input  logic        PC_write,
  input  logic        IFID_write,
  input  logic        IF_flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] IFID_instruction,
  output logic [31:0] IFID_pc_plus4,
  output logic        IFID_valid,
  output logic        fetch_busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait,
  output logic [31:0] perf_flush
`endif
);

  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StHold  = 2'd1,
    StDrain = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] issue_addr_q, issue_addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;
  logic        deliver;
  logic [31:0] deliver_instr;

  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32
  assign redirect = (pc_src != 2'b00);

  always_comb begin
    target = pc_plus4;
    unique case (pc_src)
      2'b01:   target = branch_target;
      2'b10:   target = jump_target;
      2'b11:   target = reg_target;
      default: target = pc_plus4;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    issue_addr_d  = issue_addr_q;
    buf_d         = buf_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc4_d    = ifid_pc4_q;
    ifid_valid_d  = ifid_valid_q;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;

    unique case (state_q)
      StReq: begin
        // Remember the address in flight so it stays stable if we have to drain.
        issue_addr_d = pc_q;
        if (redirect) begin
          pc_d = target;
          // A response arriving this cycle belongs to the old path; consume and drop it.
          state_d = imem_ack ? StReq : StDrain;
        end else if (imem_ack && !IF_flush) begin
          if (IFID_write) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
          end else begin
            buf_d   = imem_rdata;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = target;
          buf_d   = '0;
          state_d = StReq;
        end else if (IF_flush) begin
          // Buffered word is squashed; refetch from the held pc.
          buf_d   = '0;
          state_d = StReq;
        end else if (IFID_write) begin
          deliver       = 1'b1;
          deliver_instr = buf_q;
          buf_d         = '0;
          state_d       = StReq;
        end
      end
      StDrain: begin
        if (redirect) begin
          pc_d = target;
        end
        if (imem_ack) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    // Redirects never coincide with a delivery, so this cannot override a target.
    if (deliver && PC_write) begin
      pc_d = pc_plus4;
    end

    if (IF_flush) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (deliver) begin
      ifid_instr_d = deliver_instr;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
    end else if (IFID_write) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      issue_addr_q <= RESET_PC;
      buf_q        <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      issue_addr_q <= issue_addr_d;
      buf_q        <= buf_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Request is suppressed while reset is held so nothing is issued until rst_n rises.
  assign imem_req         = rst_n && (state_q != StHold);
  assign imem_addr        = (state_q == StDrain) ? issue_addr_q : pc_q;
  assign pc               = pc_q;
  assign IFID_instruction = ifid_instr_q;
  assign IFID_pc_plus4    = ifid_pc4_q;
  assign IFID_valid       = ifid_valid_q;
  assign fetch_busy       = (state_q == StHold) || (imem_req && !imem_ack);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_wait_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_wait_q    <= '0;
      perf_flush_q   <= '0;
    end else begin
      if (deliver) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if ((state_q != StHold) && !imem_ack) begin
        perf_wait_q <= perf_wait_q + 32'd1;
      end
      if (IF_flush) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_wait    = perf_wait_q;
  assign perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: expected IF/ID deliveries are queued when the ack is
// driven and popped when IF/ID shows them.
module tb_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jump_target, reg_target;
  logic        PC_write, IFID_write, IF_flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] IFID_instruction, IFID_pc_plus4;
  logic        IFID_valid;
  logic        fetch_busy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_wait, perf_flush;
`endif

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(Nop)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_src          (pc_src),
    .branch_target   (branch_target),
    .jump_target     (jump_target),
    .reg_target      (reg_target),
    .PC_write        (PC_write),
    .IFID_write      (IFID_write),
    .IF_flush        (IF_flush),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .pc              (pc),
    .IFID_instruction(IFID_instruction),
    .IFID_pc_plus4   (IFID_pc_plus4),
    .IFID_valid      (IFID_valid),
    .fetch_busy      (fetch_busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_wait       (perf_wait),
    .perf_flush      (perf_flush)
`endif
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("ifid_instr", IFID_instruction, e.instr);
    chk("ifid_pc4", IFID_pc_plus4, e.pc4);
    chk("ifid_valid", 32'(IFID_valid), 32'd1);
  endtask

  // Normal fetch at exp_pc with `lat` wait cycles before the ack.
  task automatic fetch(input logic [31:0] data, input int lat);
    for (int i = 0; i < lat; i++) begin
      imem_ack = 1'b0;
      #1;
      chk("req_wait", 32'(imem_req), 32'd1);
      chk("busy_wait", 32'(fetch_busy), 32'd1);
      cycle();
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    #1;
    chk("addr", imem_addr, exp_pc);
    sb.push_back('{instr: data, pc4: exp_pc + 32'd4});
    cycle();
    imem_ack = 1'b0;
    pop_check();
    exp_pc = exp_pc + 32'd4;
    chk("pc", pc, exp_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w0, f0;
    rst_n = 1'b0; pc_src = 2'b00;
    branch_target = '0; jump_target = '0; reg_target = '0;
    PC_write = 1'b1; IFID_write = 1'b1; IF_flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    cycle();
    cycle();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", IFID_instruction, Nop);
    chk("rst_pc4", IFID_pc_plus4, 32'h0);
    chk("rst_valid", 32'(IFID_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_f", perf_fetched, 32'd0);
    chk("rst_perf_w", perf_wait, 32'd0);
    chk("rst_perf_x", perf_flush, 32'd0);
`endif
    exp_pc = 32'h0;

    // Zero-wait fetch.
    fetch(32'h2002_0005, 0);

    // Ack while IF/ID stalled: word buffered, IF/ID held for 3 cycles.
    IFID_write = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hA000_0001;
    cycle();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_busy", 32'(fetch_busy), 32'd1);
      chk("hold_instr", IFID_instruction, 32'h2002_0005);
      chk("hold_pc", pc, 32'h4);
      cycle();
    end
    IFID_write = 1'b1;
    sb.push_back('{instr: 32'hA000_0001, pc4: 32'h8});
    cycle();
    pop_check();
    exp_pc = 32'h8;
    chk("hold_rel_pc", pc, exp_pc);
    chk("hold_rel_req", 32'(imem_req), 32'd1);

    // Jump while awaiting ack -> drain the old request at 8.
    pc_src = 2'b10; jump_target = 32'h40;
    cycle();
    pc_src = 2'b00;
    #1;
    chk("jmp_pc", pc, 32'h40);
    chk("drain_addr", imem_addr, 32'h8);
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_bubble", 32'(IFID_valid), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
    cycle();
    imem_ack = 1'b0;
    #1;
    chk("post_drain_addr", imem_addr, 32'h40);
    chk("drop_valid", 32'(IFID_valid), 32'd0);

    // Branch to 0x100 while awaiting ack at 0x40.
    pc_src = 2'b01; branch_target = 32'h100;
    cycle();
    pc_src = 2'b00;
    #1;
    chk("br_pc", pc, 32'h100);
    chk("br_drain_addr", imem_addr, 32'h40);
    chk("br_busy", 32'(fetch_busy), 32'd1);
    cycle();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
    cycle();
    imem_ack = 1'b0;
    #1;
    chk("stale_valid", 32'(IFID_valid), 32'd0);
    chk("stale_instr", IFID_instruction, Nop);
    chk("br_addr", imem_addr, 32'h100);
    exp_pc = 32'h100;
    fetch(32'h1111_0001, 1);

    // Flush with ack and PC_write=0: dropped, pc unchanged, same address refetched.
    IF_flush = 1'b1; PC_write = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h2222_0002;
    cycle();
    imem_ack = 1'b0; IF_flush = 1'b0;
    #1;
    chk("fl_valid", 32'(IFID_valid), 32'd0);
    chk("fl_instr", IFID_instruction, Nop);
    chk("fl_pc4", IFID_pc_plus4, 32'h0);
    chk("fl_pc", pc, 32'h104);
    chk("fl_addr", imem_addr, 32'h104);
    chk("fl_req", 32'(imem_req), 32'd1);

    // Delivery with PC_write=0: IF/ID loads, pc holds.
    imem_ack = 1'b1; imem_rdata = 32'h3333_0003;
    sb.push_back('{instr: 32'h3333_0003, pc4: 32'h108});
    cycle();
    imem_ack = 1'b0; PC_write = 1'b1;
    pop_check();
    chk("pcw0_pc", pc, 32'h104);

    // Register redirect from HOLD to the top of the address space.
    IFID_write = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h4444_0004;
    cycle();
    imem_ack = 1'b0;
    pc_src = 2'b11; reg_target = 32'hFFFF_FFFC;
    cycle();
    pc_src = 2'b00; IFID_write = 1'b1;
    #1;
    chk("jr_pc", pc, 32'hFFFF_FFFC);
    chk("jr_req", 32'(imem_req), 32'd1);
    chk("jr_held", IFID_instruction, 32'h3333_0003);
    exp_pc = 32'hFFFF_FFFC;
    fetch(32'h5555_0005, 0);
    chk("wrap_pc", pc, 32'h0);

`ifdef FETCH_PERF_EN
    w0 = perf_wait; f0 = perf_fetched;
    fetch(32'h6666_0006, 2);
    chk("perf_wait", perf_wait - w0, 32'd2);
    chk("perf_fetched", perf_fetched - f0, 32'd1);
    chk("perf_flush", perf_flush, 32'd1);
`else
    w0 = '0; f0 = '0;
    fetch(32'h6666_0006, 2);
`endif

    // Reset while a request is outstanding.
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_valid", 32'(IFID_valid), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_addr", imem_addr, 32'h0);
    exp_pc = 32'h0;
    fetch(32'h7777_0007, 1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
